// File: rtl/elem_pkg.sv
// Shared types for the per-element pulse sequencer: command and sideband
// records, mode encodings and FSM states.
package elem_pkg;

   localparam int ENV_AW  = 12;
   localparam int AMP_W   = 16;
   localparam int ENV_DW  = 16;
   localparam int FREQ_W  = 9;
   localparam int PHASE_W = 17;

   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_LOOP   = 2'b01;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [ENV_AW-1:0]  envstart;
      logic [ENV_AW-1:0]  envlength;
      logic [AMP_W-1:0]   ampx;
      logic [FREQ_W-1:0]  freqaddr;
      logic [PHASE_W-1:0] pini;
      logic [1:0]         mode;
   } cmd_t;

   typedef struct packed {
      logic               first;
      logic               last;
      logic [FREQ_W-1:0]  freq;
      logic [PHASE_W-1:0] phase;
   } sideband_t;

   // Codes 1x behave as single-shot, so only 01 selects looping.
   function automatic logic is_loop(input logic [1:0] m);
      return m == MODE_LOOP;
   endfunction

endpackage

// File: rtl/elem_scale.sv
// Signed envelope x amplitude scaler: round-half-up, shift by AMP_WIDTH-1,
// saturate to the sample width, one register stage.
module elem_scale #(
   parameter int ENV_DATA_WIDTH = 16,
   parameter int AMP_WIDTH      = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   input  logic signed [ENV_DATA_WIDTH-1:0] env_data,
   input  logic signed [AMP_WIDTH-1:0]      ampx,
   output logic                             out_valid,
   output logic signed [ENV_DATA_WIDTH-1:0] sample
);

   localparam int PW = ENV_DATA_WIDTH + AMP_WIDTH;
   localparam logic signed [PW:0] RND  = (PW+1)'(2 ** (AMP_WIDTH - 2));
   localparam logic signed [PW:0] MAXV = (PW+1)'(2 ** (ENV_DATA_WIDTH - 1) - 1);
   localparam logic signed [PW:0] MINV = (PW+1)'(-(2 ** (ENV_DATA_WIDTH - 1)));

   logic signed [PW-1:0]             prod;
   logic signed [PW:0]               rounded;
   logic signed [PW:0]               shifted;
   logic signed [ENV_DATA_WIDTH-1:0] sat;

   assign prod    = PW'(env_data) * PW'(ampx);
   assign rounded = (PW+1)'(prod) + RND;
   assign shifted = rounded >>> (AMP_WIDTH - 1);

   // Only full-scale negative squared exceeds the range, but clamp both ends.
   always_comb begin
      sat = shifted[ENV_DATA_WIDTH-1:0];
      if (shifted > MAXV)
         sat = MAXV[ENV_DATA_WIDTH-1:0];
      else if (shifted < MINV)
         sat = MINV[ENV_DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         sample    <= '0;
      end else begin
         out_valid <= in_valid;
         sample    <= in_valid ? sat : '0;
      end
   end

endmodule

// File: rtl/elem_seq.sv
// Per-element pulse sequencer: walks envelope memory per command, scales the
// samples and emits them with an aligned freq/phase sideband.
module elem_seq
   import elem_pkg::*;
#(
   parameter int ENV_ADDR_WIDTH = ENV_AW,
   parameter int AMP_WIDTH      = AMP_W,
   parameter int ENV_DATA_WIDTH = ENV_DW,
   parameter int FREQ_WIDTH     = FREQ_W,
   parameter int PHASE_WIDTH    = PHASE_W,
   parameter int ENV_RD_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmdstb,
   input  logic [ENV_ADDR_WIDTH-1:0] envstart,
   input  logic [ENV_ADDR_WIDTH-1:0] envlength,
   input  logic [AMP_WIDTH-1:0]      ampx,
   input  logic [FREQ_WIDTH-1:0]     freqaddr,
   input  logic [PHASE_WIDTH-1:0]    pini,
   input  logic [1:0]                mode,
   output logic                      busy,
   output logic                      env_rd_en,
   output logic [ENV_ADDR_WIDTH-1:0] env_addr,
   input  logic [ENV_DATA_WIDTH-1:0] env_data,
   output logic                      sample_valid,
   output logic                      sample_first,
   output logic                      sample_last,
   output logic [ENV_DATA_WIDTH-1:0] sample_out,
   output logic [FREQ_WIDTH-1:0]     freq_out,
   output logic [PHASE_WIDTH-1:0]    phase_out,
   output logic                      overflow
);

   localparam int LAT = ENV_RD_LATENCY;

   state_t                    state_reg, state_next;
   cmd_t                      act_reg, act_next, pend_reg, pend_next;
   cmd_t                      cmd_in, load_cmd;
   logic                      pend_valid_reg, pend_valid_next;
   logic [ENV_ADDR_WIDTH-1:0] addr_reg, addr_next, cnt_reg, cnt_next;
   logic                      first_reg, first_next;
   logic                      overflow_reg, overflow_next;
   logic [2:0]                drain_reg, drain_next;
   logic                      load_en, cmd_ok, last_read, act_loop, rd_en;
   sideband_t                 rd_sb, sb_out_reg;
   logic                      valid_d_reg;

   logic                      vpipe_reg    [LAT];
   sideband_t                 sb_pipe_reg  [LAT];
   logic [AMP_WIDTH-1:0]      amp_pipe_reg [LAT];

   assign cmd_in    = '{envstart: envstart, envlength: envlength, ampx: ampx,
                        freqaddr: freqaddr, pini: pini, mode: mode};
   assign cmd_ok    = cmdstb && (envlength != '0);
   assign act_loop  = is_loop(act_reg.mode);
   assign last_read = (cnt_reg == act_reg.envlength - ENV_ADDR_WIDTH'(1));
   assign rd_en     = (state_reg == RUN);

   always_comb begin
      state_next      = state_reg;
      act_next        = act_reg;
      pend_next       = pend_reg;
      pend_valid_next = pend_valid_reg;
      addr_next       = addr_reg;
      cnt_next        = cnt_reg;
      first_next      = first_reg;
      drain_next      = drain_reg;
      overflow_next   = overflow_reg;
      load_en         = 1'b0;
      load_cmd        = cmd_in;
      case (state_reg)
         IDLE: load_en = cmd_ok;
         RUN: begin
            addr_next  = addr_reg + ENV_ADDR_WIDTH'(1);
            cnt_next   = cnt_reg + ENV_ADDR_WIDTH'(1);
            first_next = 1'b0;
            if (act_loop) begin
               // Any new command pre-empts a loop immediately.
               if (cmd_ok)
                  load_en = 1'b1;
               else if (last_read) begin
                  addr_next = act_reg.envstart;
                  cnt_next  = '0;
               end
            end else if (last_read) begin
               if (pend_valid_reg) begin
                  load_en         = 1'b1;
                  load_cmd        = pend_reg;
                  pend_valid_next = 1'b0;
                  overflow_next   = overflow_reg | cmd_ok;
               end else if (cmd_ok) begin
                  load_en = 1'b1;
               end else begin
                  state_next = DRAIN;
                  drain_next = '0;
               end
            end else if (cmd_ok) begin
               if (pend_valid_reg)
                  overflow_next = 1'b1;
               else begin
                  pend_next       = cmd_in;
                  pend_valid_next = 1'b1;
               end
            end
         end
         DRAIN: begin
            drain_next = drain_reg + 3'd1;
            if (cmd_ok)
               load_en = 1'b1;
            else if (drain_reg == 3'(LAT))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (load_en) begin
         act_next   = load_cmd;
         addr_next  = load_cmd.envstart;
         cnt_next   = '0;
         first_next = 1'b1;
         state_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         act_reg        <= '{mode: MODE_SINGLE, default: '0};
         pend_reg       <= '{mode: MODE_SINGLE, default: '0};
         pend_valid_reg <= 1'b0;
         addr_reg       <= '0;
         cnt_reg        <= '0;
         first_reg      <= 1'b0;
         drain_reg      <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         act_reg        <= act_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
         addr_reg       <= addr_next;
         cnt_reg        <= cnt_next;
         first_reg      <= first_next;
         drain_reg      <= drain_next;
         overflow_reg   <= overflow_next;
      end
   end

   assign rd_sb = '{first: first_reg, last: !act_loop && last_read,
                    freq: act_reg.freqaddr, phase: act_reg.pini};

   // Sideband and amplitude ride alongside each read until env_data returns.
   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) begin
                  vpipe_reg[gi]    <= 1'b0;
                  sb_pipe_reg[gi]  <= '0;
                  amp_pipe_reg[gi] <= '0;
               end else begin
                  vpipe_reg[gi]    <= rd_en;
                  sb_pipe_reg[gi]  <= rd_sb;
                  amp_pipe_reg[gi] <= act_reg.ampx;
               end
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (reset) begin
                  vpipe_reg[gi]    <= 1'b0;
                  sb_pipe_reg[gi]  <= '0;
                  amp_pipe_reg[gi] <= '0;
               end else begin
                  vpipe_reg[gi]    <= vpipe_reg[gi-1];
                  sb_pipe_reg[gi]  <= sb_pipe_reg[gi-1];
                  amp_pipe_reg[gi] <= amp_pipe_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   elem_scale #(
      .ENV_DATA_WIDTH(ENV_DATA_WIDTH),
      .AMP_WIDTH     (AMP_WIDTH)
   ) u_scale (
      .clk      (clk),
      .reset    (reset),
      .in_valid (vpipe_reg[LAT-1]),
      .env_data (env_data),
      .ampx     (amp_pipe_reg[LAT-1]),
      .out_valid(sample_valid),
      .sample   (sample_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sb_out_reg  <= '0;
         valid_d_reg <= 1'b0;
      end else begin
         sb_out_reg  <= vpipe_reg[LAT-1] ? sb_pipe_reg[LAT-1] : '0;
         valid_d_reg <= sample_valid;
      end
   end

   // valid_d_reg keeps busy high for the cycle after the final sample.
   always_comb begin
      busy = (state_reg != IDLE) | pend_valid_reg | sample_valid | valid_d_reg;
      for (int i = 0; i < LAT; i++)
         busy = busy | vpipe_reg[i];
   end

   assign env_rd_en    = rd_en;
   assign env_addr     = addr_reg;
   assign sample_first = sb_out_reg.first;
   assign sample_last  = sb_out_reg.last;
   assign freq_out     = sb_out_reg.freq;
   assign phase_out    = sb_out_reg.phase;
   assign overflow     = overflow_reg;

endmodule
